// File: rtl/uart_tx_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer_if
// Description : Byte-in / serial-out bundle of the UART transmit stage.
//               The master side (upstream enable logic) offers a byte with
//               valid_i. The slave side (serializer) reports ready_o and
//               busy_o and drives the serial line txd_o.
// Signals     : data_i  [7:0] byte to send
//               valid_i       data_i is valid
//               ready_o       serializer can accept a byte
//               busy_o        frame in progress
//               txd_o         serial line, idle high
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_serializer_if;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic       busy_o;
    logic       txd_o;

    modport master (
        output data_i,
        output valid_i,
        input  ready_o,
        input  busy_o,
        input  txd_o
    );

    modport slave (
        input  data_i,
        input  valid_i,
        output ready_o,
        output busy_o,
        output txd_o
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer
// Description : UART transmit serializer. Accepts one byte per valid/ready
//               handshake and sends it as an 8N1 / 8E1 / 8O1 frame (one or
//               two stop bits) on a registered, idle-high serial output.
//               Bit timing comes from an internal baud divider.
// Ports       : clk_i    clock, posedge
//               rst_n_i  synchronous active-low reset
//               bus      uart_tx_serializer_if.slave
//                          data_i/valid_i in, ready_o/busy_o/txd_o out
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int PARITY    = 0,           // 0 none, 1 odd, 2 even
    parameter int STOP_BITS = 1            // 1 or 2
) (
    input  wire logic              clk_i,
    input  wire logic              rst_n_i,
    uart_tx_serializer_if.slave    bus
);

    localparam int BAUD_DIV = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end
    if (BAUD_DIV < 2) begin : g_bad_baud_div
        $error("uart_tx_serializer: BAUD_DIV must be at least 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t           state,     state_d;
    logic [CNT_W-1:0] baud_cnt,  baud_d;
    logic [2:0]       bit_idx,   bit_d;
    logic [7:0]       shift_reg, shift_d;
    logic             par_bit,   par_d;
    logic             txd,       txd_d;
    logic             bit_done;

    assign bit_done = (baud_cnt == BAUD_LAST);

    always_comb begin
        state_d = state;
        baud_d  = baud_cnt;
        bit_d   = bit_idx;
        shift_d = shift_reg;
        par_d   = par_bit;

        case (state)
            ST_IDLE: begin
                // Counter held at zero so the first start bit is a full period.
                baud_d = '0;
                bit_d  = '0;
                if (bus.valid_i) begin
                    state_d = ST_START;
                    shift_d = bus.data_i;
                    par_d   = (PARITY == 1) ? ~^bus.data_i : ^bus.data_i;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_reg[7:1]};
                    if (bit_idx == 3'd7) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_idx + 3'd1;
                    end
                end else begin
                    baud_d = baud_cnt + 1'b1;
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_cnt + 1'b1;
                end
            end
            ST_STOP: begin
                // bit_idx counts stop bits here.
                if (bit_done) begin
                    baud_d = '0;
                    if (bit_idx == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        bit_d = bit_idx + 3'd1;
                    end
                end else begin
                    baud_d = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase

        // Line level is decoded from the next state so txd is a flop output.
        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_d[0];
            ST_PARITY: txd_d = par_d;
            default:   txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            txd       <= 1'b1;
        end else begin
            state     <= state_d;
            baud_cnt  <= baud_d;
            bit_idx   <= bit_d;
            shift_reg <= shift_d;
            par_bit   <= par_d;
            txd       <= txd_d;
        end
    end

    assign bus.ready_o = (state == ST_IDLE);
    assign bus.busy_o  = (state != ST_IDLE);
    assign bus.txd_o   = txd;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_serializer
// Description : Directed self-checking bench for uart_tx_serializer with
//               BAUD_DIV = 10. Three instances: 8N1, 8E2 and 8O1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serializer;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    uart_tx_serializer_if bus0 ();
    uart_tx_serializer_if bus_e ();
    uart_tx_serializer_if bus_o ();

    uart_tx_serializer #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000),
                         .PARITY(0), .STOP_BITS(1))
        dut0 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus0));

    uart_tx_serializer #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000),
                         .PARITY(2), .STOP_BITS(2))
        dut_e (.clk_i(clk), .rst_n_i(rst_n), .bus(bus_e));

    uart_tx_serializer #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000),
                         .PARITY(1), .STOP_BITS(1))
        dut_o (.clk_i(clk), .rst_n_i(rst_n), .bus(bus_o));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frames below are written position-ordered: leftmost bit is the start bit.

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            checks++;
            if (bus0.txd_o !== 1'b1 || bus0.ready_o !== 1'b1 || bus0.busy_o !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d txd=%b ready=%b busy=%b expected 1 1 0",
                         c, bus0.txd_o, bus0.ready_o, bus0.busy_o);
            end
            checks++;
            if (bus_e.txd_o !== 1'b1 || bus_e.ready_o !== 1'b1 ||
                bus_o.txd_o !== 1'b1 || bus_o.ready_o !== 1'b1) begin
                failures++;
                $display("FAIL reset_idle_par cycle=%0d e_txd=%b e_ready=%b o_txd=%b o_ready=%b expected all 1",
                         c, bus_e.txd_o, bus_e.ready_o, bus_o.txd_o, bus_o.ready_o);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_single_frame();
        logic [0:11] f;
        f = 12'b0101_0010_1111;               // 0xA5
        bus0.data_i  = 8'hA5;
        bus0.valid_i = 1'b1;
        @(negedge clk);
        bus0.valid_i = 1'b0;
        bus0.data_i  = 8'h00;
        checks++;
        if (bus0.ready_o !== 1'b0 || bus0.busy_o !== 1'b1) begin
            failures++;
            $display("FAIL accept_handshake ready=%b busy=%b expected ready=0 busy=1",
                     bus0.ready_o, bus0.busy_o);
        end
        for (int c = 0; c < 100; c++) begin
            checks++;
            if (bus0.txd_o !== f[c/10] || bus0.ready_o !== 1'b0) begin
                failures++;
                $display("FAIL frame_a5 cycle=%0d txd=%b ready=%b expected txd=%b ready=0",
                         c, bus0.txd_o, bus0.ready_o, f[c/10]);
            end
            @(negedge clk);
        end
        checks++;
        if (bus0.ready_o !== 1'b1 || bus0.txd_o !== 1'b1) begin
            failures++;
            $display("FAIL frame_a5_end ready=%b txd=%b expected ready=1 txd=1",
                     bus0.ready_o, bus0.txd_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [0:11] f1;
        logic [0:11] f2;
        f1 = 12'b0100_0000_0111;              // 0x01
        f2 = 12'b0000_0000_1111;              // 0x80
        @(negedge clk);
        bus0.data_i  = 8'h01;
        bus0.valid_i = 1'b1;
        @(negedge clk);
        bus0.data_i  = 8'h80;
        for (int c = 0; c < 100; c++) begin
            if (c == 50) bus0.data_i = 8'hFF;
            if (c == 60) bus0.data_i = 8'h80;
            checks++;
            if (bus0.txd_o !== f1[c/10] || bus0.ready_o !== 1'b0) begin
                failures++;
                $display("FAIL b2b_frame1 cycle=%0d txd=%b ready=%b expected txd=%b ready=0",
                         c, bus0.txd_o, bus0.ready_o, f1[c/10]);
            end
            @(negedge clk);
        end
        checks++;
        if (bus0.ready_o !== 1'b1 || bus0.txd_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_gap ready=%b txd=%b expected ready=1 txd=1",
                     bus0.ready_o, bus0.txd_o);
        end
        @(negedge clk);
        bus0.valid_i = 1'b0;
        for (int c = 0; c < 100; c++) begin
            checks++;
            if (bus0.txd_o !== f2[c/10] || bus0.ready_o !== 1'b0) begin
                failures++;
                $display("FAIL b2b_frame2 cycle=%0d txd=%b ready=%b expected txd=%b ready=0",
                         c, bus0.txd_o, bus0.ready_o, f2[c/10]);
            end
            @(negedge clk);
        end
        checks++;
        if (bus0.ready_o !== 1'b1 || bus0.txd_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_end ready=%b txd=%b expected ready=1 txd=1",
                     bus0.ready_o, bus0.txd_o);
        end
    endtask

    task automatic test_parity();
        logic [0:11] fe;
        logic [0:11] fo;
        fe = 12'b0111_0000_0111;              // 0x07, even parity 1, two stops
        fo = 12'b0111_0000_0011;              // 0x07, odd parity 0, one stop
        @(negedge clk);
        bus_e.data_i  = 8'h07;
        bus_e.valid_i = 1'b1;
        bus_o.data_i  = 8'h07;
        bus_o.valid_i = 1'b1;
        @(negedge clk);
        bus_e.valid_i = 1'b0;
        bus_o.valid_i = 1'b0;
        for (int c = 0; c < 120; c++) begin
            checks++;
            if (bus_e.txd_o !== fe[c/10] || bus_e.ready_o !== 1'b0) begin
                failures++;
                $display("FAIL even_2stop cycle=%0d txd=%b ready=%b expected txd=%b ready=0",
                         c, bus_e.txd_o, bus_e.ready_o, fe[c/10]);
            end
            checks++;
            if (c < 110) begin
                if (bus_o.txd_o !== fo[c/10] || bus_o.ready_o !== 1'b0) begin
                    failures++;
                    $display("FAIL odd_1stop cycle=%0d txd=%b ready=%b expected txd=%b ready=0",
                             c, bus_o.txd_o, bus_o.ready_o, fo[c/10]);
                end
            end else begin
                if (bus_o.txd_o !== 1'b1 || bus_o.ready_o !== 1'b1) begin
                    failures++;
                    $display("FAIL odd_1stop_end cycle=%0d txd=%b ready=%b expected txd=1 ready=1",
                             c, bus_o.txd_o, bus_o.ready_o);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (bus_e.ready_o !== 1'b1 || bus_e.txd_o !== 1'b1) begin
            failures++;
            $display("FAIL even_2stop_end ready=%b txd=%b expected ready=1 txd=1",
                     bus_e.ready_o, bus_e.txd_o);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [0:11] f;
        f = 12'b0001_1110_0111;               // 0x3C
        @(negedge clk);
        bus0.data_i  = 8'h00;
        bus0.valid_i = 1'b1;
        @(negedge clk);
        bus0.valid_i = 1'b0;
        for (int c = 0; c < 45; c++) begin
            checks++;
            if (bus0.txd_o !== 1'b0 || bus0.ready_o !== 1'b0) begin
                failures++;
                $display("FAIL abort_prefix cycle=%0d txd=%b ready=%b expected txd=0 ready=0",
                         c, bus0.txd_o, bus0.ready_o);
            end
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (bus0.txd_o !== 1'b1 || bus0.ready_o !== 1'b1 || bus0.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL abort_reset txd=%b ready=%b busy=%b expected 1 1 0",
                     bus0.txd_o, bus0.ready_o, bus0.busy_o);
        end
        repeat (3) @(negedge clk);
        bus0.data_i  = 8'h3C;
        bus0.valid_i = 1'b1;
        @(negedge clk);
        bus0.valid_i = 1'b0;
        for (int c = 0; c < 100; c++) begin
            checks++;
            if (bus0.txd_o !== f[c/10] || bus0.ready_o !== 1'b0) begin
                failures++;
                $display("FAIL post_abort_frame cycle=%0d txd=%b ready=%b expected txd=%b ready=0",
                         c, bus0.txd_o, bus0.ready_o, f[c/10]);
            end
            @(negedge clk);
        end
        checks++;
        if (bus0.ready_o !== 1'b1 || bus0.txd_o !== 1'b1) begin
            failures++;
            $display("FAIL post_abort_end ready=%b txd=%b expected ready=1 txd=1",
                     bus0.ready_o, bus0.txd_o);
        end
    endtask

    task automatic test_valid_ignored();
        logic [0:11] f;
        f = 12'b0010_1101_0111;               // 0x5A
        @(negedge clk);
        bus0.data_i  = 8'h5A;
        bus0.valid_i = 1'b1;
        @(negedge clk);
        bus0.valid_i = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (c == 30) begin
                bus0.data_i  = 8'hFF;
                bus0.valid_i = 1'b1;
            end
            if (c == 31) bus0.valid_i = 1'b0;
            checks++;
            if (bus0.txd_o !== f[c/10] || bus0.ready_o !== 1'b0) begin
                failures++;
                $display("FAIL ignore_frame cycle=%0d txd=%b ready=%b expected txd=%b ready=0",
                         c, bus0.txd_o, bus0.ready_o, f[c/10]);
            end
            @(negedge clk);
        end
        for (int c = 0; c < 30; c++) begin
            checks++;
            if (bus0.ready_o !== 1'b1 || bus0.txd_o !== 1'b1) begin
                failures++;
                $display("FAIL ignore_no_second cycle=%0d ready=%b txd=%b expected ready=1 txd=1",
                         c, bus0.ready_o, bus0.txd_o);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus0.data_i   = 8'h00;
        bus0.valid_i  = 1'b0;
        bus_e.data_i  = 8'h00;
        bus_e.valid_i = 1'b0;
        bus_o.data_i  = 8'h00;
        bus_o.valid_i = 1'b0;

        test_reset();
        test_single_frame();
        test_back_to_back();
        test_parity();
        test_reset_mid_frame();
        test_valid_ignored();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
